perf_monitor: RTL

PERF_MONITOR -- requirements
Module: perf_monitor

---
 rtl/perf_monitor.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/perf_monitor.sv
// -----------------------------------------------------------------------------
// perf_monitor
//
// Purpose:
//   Small performance-monitor block. It holds one free-running cycle counter
//   and NUM_EVT event counters that count while the block is in RUN. RUN ends
//   by itself after MAX_CYCLES cycles. A shadow bank keeps a stable copy of
//   the live counters for software reads. The copy is taken on snap_i and
//   automatically on entry to DONE. Each counter has a sticky overflow flag.
//
// Configuration macro:
//   PERF_MON_SAT_EN  defined   : a counter at 2^CNT_W-1 holds (saturates)
//                    undefined : a counter wraps to 0 (default build)
//   The overflow flag sets in both builds.
//
// Parameters:
//   NUM_EVT    number of event counters (1..15)
//   CNT_W      width of every counter (2..64)
//   MAX_CYCLES number of RUN cycles before the block moves to DONE
//   SEL_W      width of rd_sel_i
//
// Ports:
//   clk_i      in   clock; all state changes on its rising edge
//   rst_i      in   synchronous active-low reset
//   start_i    in   level; IDLE -> RUN
//   clear_i    in   pulse; zero everything and return to IDLE (beats start,
//                   snap and events)
//   event_i    in   NUM_EVT per-cycle event strobes
//   snap_i     in   pulse; copy the pre-edge live counters into the shadow bank
//   rd_req_i   in   read request, one per cycle, back-to-back capable
//   rd_sel_i   in   0 = cycle counter, k = event counter k-1, >NUM_EVT reads 0
//   rd_valid_o out  high one cycle after each rd_req_i
//   rd_data_o  out  shadow value as it stood before the request edge; 0 when
//                   rd_valid_o is low
//   running_o  out  high while in RUN
//   done_o     out  high while in DONE
//   ovf_o      out  sticky overflow flags; bit 0 = cycle counter,
//                   bit k = event counter k-1
// -----------------------------------------------------------------------------
module perf_monitor #(
    parameter int NUM_EVT    = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 64,
    parameter int SEL_W      = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [NUM_EVT-1:0] event_i,
    input  logic               snap_i,
    input  logic               rd_req_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic               rd_valid_o,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic               running_o,
    output logic               done_o,
    output logic [NUM_EVT:0]   ovf_o
);

    // Index 0 is the cycle counter, index k is event counter k-1, so the
    // read select maps straight onto the array index.
    localparam int NCNT = NUM_EVT + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // The end-of-run compare is done at 64 bits so that a MAX_CYCLES the
    // counter cannot represent is never reached by a wrapped value.
    localparam logic [63:0] MAX_CYC_L = 64'(MAX_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NCNT];
    logic [CNT_W-1:0] cnt_d [NCNT];
    logic [CNT_W-1:0] shd_q [NCNT];
    logic [CNT_W-1:0] shd_d [NCNT];
    logic [NCNT-1:0]  ovf_q, ovf_d;
    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    logic [NCNT-1:0]  inc;
    logic             end_run;

    // -------------------------------------------------------------------------
    // Increment enables: the cycle counter always counts in RUN, the event
    // counters follow their strobes. Outside RUN nothing counts.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so
        // that no path leaves it unassigned and no latch is inferred.
        inc = '0;
        if (state_q == ST_RUN) begin
            inc = {event_i, 1'b1};
        end
    end

    // -------------------------------------------------------------------------
    // Live counters and sticky overflow flags.
    // -------------------------------------------------------------------------
    always_comb begin
        ovf_d = ovf_q;
        for (int k = 0; k < NCNT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (inc[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    ovf_d[k] = 1'b1;
`ifdef PERF_MON_SAT_EN
                    cnt_d[k] = CNT_MAX;
`else
                    cnt_d[k] = '0;
`endif
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_ONE;
                end
            end
        end
        if (clear_i) begin
            ovf_d = '0;
            for (int k = 0; k < NCNT; k++) begin
                cnt_d[k] = '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. RUN ends on the edge where the cycle counter reaches
    // MAX_CYCLES, so the compare uses the post-increment value.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        end_run = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (64'(cnt_d[0]) == MAX_CYC_L) begin
                    state_d = ST_DONE;
                    end_run = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (clear_i) begin
            state_d = ST_IDLE;
            end_run = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Shadow bank. The auto-snap on entry to DONE captures the final counts,
    // including that edge's increments. A user snap captures the pre-edge
    // values. When both happen on one edge, the final counts win.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NCNT; k++) begin
            shd_d[k] = shd_q[k];
        end
        if (clear_i) begin
            for (int k = 0; k < NCNT; k++) begin
                shd_d[k] = '0;
            end
        end else if (end_run) begin
            shd_d = cnt_d;
        end else if (snap_i) begin
            shd_d = cnt_q;
        end
    end

    // -------------------------------------------------------------------------
    // Read port: one-cycle latency from the registered shadow bank, so a snap
    // on the request edge is not yet visible. Out-of-range selects match no
    // entry and return 0.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_valid_d = rd_req_i;
        rd_data_d  = '0;
        if (rd_req_i) begin
            for (int k = 0; k < NCNT; k++) begin
                if (32'(rd_sel_i) == k) begin
                    rd_data_d = shd_q[k];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, whatever the statement order.
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            ovf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            // NOTE: the counter and shadow arrays are reset explicitly. They
            // are visible state that must read back as zero after reset, not
            // scratch storage that could be left uninitialised.
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k] <= '0;
                shd_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            cnt_q      <= cnt_d;
            shd_q      <= shd_d;
        end
    end

    assign running_o  = (state_q == ST_RUN);
    assign done_o     = (state_q == ST_DONE);
    assign ovf_o      = ovf_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule
